// File: rtl/prio_decoder_seq.sv
// ---------------------------------------------------------------------------
// prio_decoder_seq
//
// Buffered, handshaked N-to-2^N decoder. Binary priority codes arrive on a
// valid/ready input, are queued in a 2-entry FIFO, and leave as registered
// one-hot words on a valid/ready output.
//
// Parameters:
//   N          code width; output width is 2**N
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   en         block enable; 0 freezes the queue and blocks new input
//   din        binary code to decode
//   din_valid  din is valid this cycle
//   din_ready  block can accept din this cycle (combinational, no y_ready path)
//   y          registered one-hot decode of the current code (0 when idle)
//   y_valid    y holds a valid decode
//   y_ready    consumer accepts y this cycle
//   dec_cnt    (only with DEC_COUNT_EN) 8-bit wrapping count of output
//              handshakes
//
// Optional feature macro: DEC_COUNT_EN
// ---------------------------------------------------------------------------
module prio_decoder_seq #(
    parameter int N = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N-1:0]      din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [2**N-1:0]   y,
    output logic              y_valid,
    input  logic              y_ready
`ifdef DEC_COUNT_EN
    ,
    output logic [7:0]        dec_cnt
`endif
);

    localparam int W = 2**N;

    // Output stage states
    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_HOLD  = 1'b1;

    logic [N-1:0] r_fifo [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         r_state;
    logic [W-1:0] r_y;

    logic         w_free;
    logic         w_push;
    logic         w_pop;

    function automatic logic [W-1:0] onehot(input logic [N-1:0] code);
        logic [W-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

    // din_ready is gated by rst so it reads 0 during reset even if en=1.
    assign din_ready = ~rst & en & (r_count < 2'd2);
    assign w_push    = din_valid & din_ready;
    assign w_free    = (r_state == ST_EMPTY) | y_ready;
    assign w_pop     = en & w_free & (r_count != 2'd0);

    assign y         = r_y;
    assign y_valid   = (r_state == ST_HOLD);

    // FIFO storage: data only, contents are don't-care while count says empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Output FSM: a pop always reloads y; a free stage without reload goes
    // idle and clears y so y is zero whenever y_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_y     <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_pop) begin
                        r_y     <= onehot(r_fifo[r_rd_ptr]);
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_pop) begin
                        r_y     <= onehot(r_fifo[r_rd_ptr]);
                        r_state <= ST_HOLD;
                    end else if (y_ready) begin
                        r_y     <= '0;
                        r_state <= ST_EMPTY;
                    end
                end
                default: begin
                    r_y     <= '0;
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

`ifdef DEC_COUNT_EN
    logic [7:0] r_dec_cnt;

    // Counts completed output handshakes regardless of en; wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dec_cnt <= 8'd0;
        end else if (y_valid & y_ready) begin
            r_dec_cnt <= r_dec_cnt + 8'd1;
        end
    end

    assign dec_cnt = r_dec_cnt;
`endif

endmodule

// File: tb/tb_prio_decoder_seq.sv
module tb_prio_decoder_seq;

    localparam int N = 3;
    localparam int W = 2**N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [N-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic [W-1:0] y;
    logic         y_valid;
    logic         y_ready = 1'b0;
`ifdef DEC_COUNT_EN
    logic [7:0]   dec_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: a queue of pending codes plus the code held at the output.
    logic [N-1:0] mq[$];
    logic         m_vld = 1'b0;
    logic [N-1:0] m_code = '0;
    logic [7:0]   m_cnt = 8'd0;

    prio_decoder_seq #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .y         (y),
        .y_valid   (y_valid),
        .y_ready   (y_ready)
`ifdef DEC_COUNT_EN
        ,
        .dec_cnt   (dec_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] exp_y();
        logic [W-1:0] v;
        v = '0;
        if (m_vld) v = W'(1) << m_code;
        return v;
    endfunction

    function automatic logic exp_ready();
        return !rst && en && (mq.size() < 2);
    endfunction

    // Advance one clock edge, stepping the model with the inputs seen at the
    // edge, then wait 1 time unit so DUT outputs have settled.
    task automatic tick();
        logic free, push, pop;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_vld = 1'b0;
            m_cnt = 8'd0;
        end else begin
            free = !m_vld || y_ready;
            push = din_valid && en && (mq.size() < 2);
            pop  = en && free && (mq.size() > 0);
            if (m_vld && y_ready) m_cnt = m_cnt + 8'd1;
            if (pop) begin
                m_code = mq.pop_front();
                m_vld  = 1'b1;
            end else if (free) begin
                m_vld = 1'b0;
            end
            if (push) mq.push_back(din);
        end
        #1;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        y_ready   = 1'b1;
        en        = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        tick();
        tick();
        checks++;
        if (y !== '0 || y_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: y=%h y_valid=%b required y=00 y_valid=0", y, y_valid);
        end
        checks++;
        if (din_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_din_ready: got %b required 0", din_ready);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (din_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_din_ready: got %b required 1", din_ready);
        end
    endtask

    task automatic test_single();
        en = 1'b1; y_ready = 1'b1;
        din = 3'd5; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        checks++;
        if (y_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: y_valid=%b required 0", y_valid);
        end
        tick();
        checks++;
        if (y !== 8'b0010_0000 || y_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_decode: y=%b y_valid=%b required 00100000/1", y, y_valid);
        end
        tick();
        checks++;
        if (y !== '0 || y_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: y=%b y_valid=%b required 0/0", y, y_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_seq [4];
        logic [W-1:0] got[$];
        logic         acc;
        exp_seq[0] = 8'h01; exp_seq[1] = 8'h80; exp_seq[2] = 8'h04; exp_seq[3] = 8'h10;
        en = 1'b1; y_ready = 1'b0; din_valid = 1'b1;
        din = 3'd0; tick();
        din = 3'd7; tick();
        din = 3'd2; tick();
        din = 3'd4;
        checks++;
        if (din_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full_ready: got %b required 0", din_ready);
        end
        tick(); tick();
        checks++;
        if (y !== 8'h01 || y_valid !== 1'b1 || din_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall: y=%h y_valid=%b din_ready=%b required 01/1/0", y, y_valid, din_ready);
        end
        y_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (y_valid && y_ready) got.push_back(y);
            acc = din_valid && din_ready;
            tick();
            if (acc) din_valid = 1'b0;
        end
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL bp_count: got %0d outputs required 4", got.size());
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_seq[i]) begin
                errors++;
                $display("FAIL bp_order[%0d]: got %h required %h", i, got[i], exp_seq[i]);
            end
        end
    endtask

    task automatic test_streaming();
        logic [N-1:0] exp_c;
        en = 1'b1; y_ready = 1'b1; din_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            din = N'(i % 8);
            checks++;
            if (din_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready[%0d]: got %b required 1", i, din_ready);
            end
            if (i == 16) din_valid = 1'b0;
            tick();
            if (i >= 1) begin
                exp_c = N'((i - 1) % 8);
                checks++;
                if (y !== (W'(1) << exp_c) || y_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_y[%0d]: y=%h y_valid=%b required %h/1", i, y, y_valid, W'(1) << exp_c);
                end
            end
        end
        din_valid = 1'b0;
        tick();
    endtask

    task automatic test_enable_freeze();
        logic [N-1:0] a, b, c;
        a = N'($urandom); b = N'($urandom); c = N'($urandom);
        en = 1'b1; y_ready = 1'b0; din_valid = 1'b1;
        din = a; tick();
        din = b; tick();
        din = c; tick();
        din_valid = 1'b0;
        en = 1'b0; y_ready = 1'b1;
        checks++;
        if (y !== (W'(1) << a) || y_valid !== 1'b1 || din_ready !== 1'b0) begin
            errors++;
            $display("FAIL freeze_hold: y=%h y_valid=%b din_ready=%b required %h/1/0", y, y_valid, din_ready, W'(1) << a);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (y !== '0 || y_valid !== 1'b0 || din_ready !== 1'b0) begin
                errors++;
                $display("FAIL freeze_idle[%0d]: y=%h y_valid=%b din_ready=%b required 0/0/0", i, y, y_valid, din_ready);
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if (y !== (W'(1) << b) || y_valid !== 1'b1) begin
            errors++;
            $display("FAIL freeze_resume_b: y=%h required %h", y, W'(1) << b);
        end
        tick();
        checks++;
        if (y !== (W'(1) << c) || y_valid !== 1'b1) begin
            errors++;
            $display("FAIL freeze_resume_c: y=%h required %h", y, W'(1) << c);
        end
        tick();
    endtask

    task automatic test_async_reset();
        logic [N-1:0] k;
        en = 1'b1; y_ready = 1'b0; din_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = N'($urandom);
            tick();
        end
        din_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (y !== '0 || y_valid !== 1'b0 || din_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: y=%h y_valid=%b din_ready=%b required 0/0/0", y, y_valid, din_ready);
        end
        tick();
        #2 rst = 1'b0;
        #1;
        k = N'($urandom);
        y_ready = 1'b1; din = k; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        checks++;
        if (y !== (W'(1) << k) || y_valid !== 1'b1) begin
            errors++;
            $display("FAIL async_rst_after: y=%h y_valid=%b required %h/1", y, y_valid, W'(1) << k);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 7) != 0);
            din_valid = $urandom_range(0, 1) == 1;
            y_ready   = ($urandom_range(0, 3) != 0);
            din       = N'($urandom);
            #1;
            checks++;
            if (din_ready !== exp_ready()) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got %b required %b", i, din_ready, exp_ready());
            end
            tick();
            checks++;
            if (y !== exp_y() || y_valid !== m_vld) begin
                errors++;
                $display("FAIL rand_out[%0d]: y=%h y_valid=%b required %h/%b", i, y, y_valid, exp_y(), m_vld);
            end
`ifdef DEC_COUNT_EN
            checks++;
            if (dec_cnt !== m_cnt) begin
                errors++;
                $display("FAIL rand_cnt[%0d]: got %0d required %0d", i, dec_cnt, m_cnt);
            end
`endif
        end
        idle(4);
    endtask

`ifdef DEC_COUNT_EN
    task automatic test_dec_count();
        int hs, pushes;
        rst = 1'b1;
        tick();
        #2 rst = 1'b0;
        #1;
        hs = 0; pushes = 0;
        en = 1'b1; y_ready = 1'b1;
        for (int i = 0; i < 400 && hs < 257; i++) begin
            din_valid = (pushes < 257);
            din = N'($urandom);
            #1;
            if (y_valid && y_ready) hs++;
            if (din_valid && din_ready) pushes++;
            tick();
        end
        din_valid = 1'b0; y_ready = 1'b0;
        tick();
        checks++;
        if (hs != 257) begin
            errors++;
            $display("FAIL cnt_budget: got %0d handshakes required 257", hs);
        end
        checks++;
        if (dec_cnt !== 8'd1) begin
            errors++;
            $display("FAIL cnt_wrap: got %0d required 1", dec_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        idle(3);
        test_backpressure();
        idle(3);
        test_streaming();
        idle(3);
        test_enable_freeze();
        idle(3);
        test_async_reset();
        idle(3);
        test_random();
`ifdef DEC_COUNT_EN
        test_dec_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prio_decoder_seq.md
Name: prio_decoder_seq

Overview:
- Buffered, handshaked N-to-2^N decoder. It is the decode end of the priority-encoded index path.
- Accepts binary priority codes on a valid/ready input, queues them in a 2-entry FIFO, and presents each as a registered one-hot word on a valid/ready output.
- Sits between the priority encoder's code output and the per-line grant/service logic.

Parameters:
- N, 3, code width. The output width is 2**N.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  block enable; 0 freezes the queue and blocks new input
- din  input  N  binary code to decode
- din_valid  input  1  din is valid this cycle
- din_ready  output  1  block can accept din this cycle
- y  output  2**N  registered one-hot decode of the current code
- y_valid  output  1  y holds a valid decode
- y_ready  input  1  consumer accepts y this cycle

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous and active-high.
- Reset values:
  - FIFO count=0, read/write pointers=0.
  - y=0, y_valid=0.
  - din_ready=0 while rst=1.
- din_ready is combinational: en & (count<2). It does not depend on y_ready, so there is no combinational path from y_ready to din_ready.
- Push: din_valid & din_ready at a clock edge writes din at wr_ptr; wr_ptr toggles.
- Output stage:
  - "free" = !y_valid | y_ready.
  - On an edge where en=1, free=1 and count>0: y <= 1<<fifo[rd_ptr], y_valid <= 1, pop (rd_ptr toggles).
  - On an edge where free=1 and the stage is not reloaded (count=0 or en=0): y_valid <= 0 and y <= 0, once the handshake completes.
- y is all zeros whenever y_valid=0. When y_valid=1, exactly one bit of y is set.
- y and y_valid are stable while y_valid=1 & y_ready=0, including when en=0.
- Latency:
  - A code pushed at edge k into an empty FIFO appears on y with y_valid=1 after edge k+1.
  - Sustained throughput is 1 code/cycle when din_valid=y_ready=1.
- Count update per edge: +1 on push only, -1 on pop only, unchanged on both or neither.
  - Push and pop together at count=1 leaves count=1.
  - At count=2 no push occurs (din_ready=0), even if a pop occurs that edge.
- Pointers are 1 bit and wrap 1->0 naturally.
- Ordering is strict FIFO; codes are never dropped, duplicated or reordered.
- en=0 mid-operation:
  - No push, no pop; queued entries are retained.
  - A y already valid still completes its handshake on y_ready. After that, y_valid=0 until en returns to 1.
- rst mid-operation: asynchronously returns to reset values; queued codes are discarded.
- Every N-bit code is legal; no error conditions exist.
- Structure: two-state output FSM, EMPTY (y_valid=0) and HOLD (y_valid=1).
  - EMPTY->HOLD on a load.
  - HOLD->HOLD on stall, or on handshake plus reload.
  - HOLD->EMPTY on handshake without reload.

Optional Feature:
- Macro DEC_COUNT_EN.
- When defined:
  - Adds output port dec_cnt (8 bits).
  - Resets to 0 and increments on each y_valid & y_ready edge.
  - Wraps 255->0.
  - Frozen by rst only, not by en.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then single code:
  - Stimulus: rst=1 for 2 cycles, release, en=1, y_ready=1, din=3'd5 valid for 1 cycle.
  - Response: y=8'b00100000 with y_valid=1 exactly one cycle after acceptance, then y=0, y_valid=0.
- Backpressure fill:
  - Stimulus: y_ready=0, push codes 0,7,2,4 back-to-back.
  - Response:
    - 0 loads to y=8'h01.
    - 7 and 2 fill the FIFO; din_ready=0 from the next cycle, so 4 is held.
    - Raise y_ready: outputs 8'h01, 8'h80, 8'h04, 8'h10 in order.
- Streaming:
  - Stimulus: din_valid=y_ready=1, din cycling 0..7 for 16 cycles.
  - Response: y is one-hot of each code with 1-cycle latency; no bubbles; din_ready stays 1.
- Enable freeze:
  - Stimulus: two codes queued and y valid, en=0, y_ready=1.
  - Response:
    - The current y completes; then y_valid=0 and din_ready=0.
    - The queued codes emerge in order after en=1.
- Async reset mid-stream:
  - Stimulus: assert rst between clock edges while count=2 and y_valid=1.
  - Response: y=0, y_valid=0 and din_ready=0 immediately; after release, the first new code decodes correctly.
- With DEC_COUNT_EN:
  - Stimulus: 257 output handshakes.
  - Response: dec_cnt=1.
